// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the 32-point FFT stage sequencer: default sizing,
// sequencer state encoding and the twiddle-ROM stride helper.
// ---------------------------------------------------------------------------
package fft_pkg;

   localparam int unsigned FFT_POINTS    = 32;
   localparam int unsigned NUM_STAGES_DF = $clog2(FFT_POINTS);
   localparam int unsigned SEL_STEPS_DF  = 5;
   localparam int unsigned STAGE_W_DF    = 3;
   localparam int unsigned SEL_W         = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } seq_state_e;

   // Twiddle index stride halves with every stage: 1 << (num_stages-1-stage).
   function automatic logic [31:0] tw_stride_f(input int unsigned num_stages,
                                               input int unsigned stage);
      return 32'(1) << (num_stages - 1 - stage);
   endfunction

endpackage

// File: rtl/fft_phase_counter.sv
// ---------------------------------------------------------------------------
// fft_phase_counter
// MAC phase (sel) and stage index counter pair. sel runs 0..SEL_STEPS-1 and
// carries into the stage index; the terminal step (last phase of the last
// stage) returns both counters to 0 so they never run past their limits.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   en_i         advance one phase
//   clr_i        synchronous clear (dominates en_i)
//   sel_o        current MAC phase
//   stage_o      current stage index
//   term_c_o     combinational: current step is the final one of the run
// ---------------------------------------------------------------------------
module fft_phase_counter
   import fft_pkg::*;
#(
   parameter int unsigned NUM_STAGES = NUM_STAGES_DF,
   parameter int unsigned SEL_STEPS  = SEL_STEPS_DF,
   parameter int unsigned STAGE_W    = STAGE_W_DF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en_i,
   input  logic               clr_i,
   output logic [SEL_W-1:0]   sel_o,
   output logic [STAGE_W-1:0] stage_o,
   output logic               term_c_o
);

   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [STAGE_W-1:0] stage_q, stage_d;
   logic               sel_last_c;

   assign sel_last_c = (sel_q == SEL_W'(SEL_STEPS - 1));
   assign term_c_o   = sel_last_c && (stage_q == STAGE_W'(NUM_STAGES - 1));

   // Next-count logic: phase wrap carries into the stage index.
   always_comb begin
      sel_d   = sel_q;
      stage_d = stage_q;
      if (clr_i) begin
         sel_d   = '0;
         stage_d = '0;
      end else if (en_i) begin
         if (sel_last_c) begin
            sel_d   = '0;
            stage_d = term_c_o ? '0 : stage_q + STAGE_W'(1);
         end else begin
            sel_d = sel_q + SEL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sel_q   <= '0;
         stage_q <= '0;
      end else begin
         sel_q   <= sel_d;
         stage_q <= stage_d;
      end
   end

   assign sel_o   = sel_q;
   assign stage_o = stage_q;

endmodule

// File: rtl/fft_stage_sequencer.sv
// ---------------------------------------------------------------------------
// fft_stage_sequencer
// Steps the five FFT stage datapaths through their MAC micro-sequence, one
// stage at a time, after a start request.
// Ports:
//   clk, reset    clock, synchronous active-low reset
//   start         one-cycle run request (ignored while running)
//   hold          stall; freezes sequencing while high in RUN
//   sel           MAC phase select
//   PU_enable     processing-unit enable (RUN and not held)
//   stage_idx     active stage
//   stage_en      one-hot capture strobe on the last phase of a stage
//   tw_stride     twiddle ROM stride for the active stage
//   busy, done    run in progress / one-cycle completion pulse
//   cycle_count   (FFT_SEQ_PERF_EN only) RUN cycles of the last run, saturating
// Build option: define FFT_SEQ_PERF_EN to add the cycle_count port.
// ---------------------------------------------------------------------------
module fft_stage_sequencer
   import fft_pkg::*;
#(
   parameter int unsigned NUM_STAGES = NUM_STAGES_DF,
   parameter int unsigned SEL_STEPS  = SEL_STEPS_DF,
   parameter int unsigned STAGE_W    = STAGE_W_DF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  hold,
   output logic [SEL_W-1:0]      sel,
   output logic                  PU_enable,
   output logic [STAGE_W-1:0]    stage_idx,
   output logic [NUM_STAGES-1:0] stage_en,
   output logic [NUM_STAGES-1:0] tw_stride,
   output logic                  busy,
`ifdef FFT_SEQ_PERF_EN
   output logic                  done,
   output logic [15:0]           cycle_count
`else
   output logic                  done
`endif
);

   seq_state_e state_q, state_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       run_c, step_c, accept_c, term_c, sel_last_c;

   assign run_c    = (state_q == ST_RUN);
   assign step_c   = run_c && !hold;
   assign accept_c = start && !run_c;

   fft_phase_counter #(
      .NUM_STAGES (NUM_STAGES),
      .SEL_STEPS  (SEL_STEPS),
      .STAGE_W    (STAGE_W)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .en_i     (step_c),
      .clr_i    (accept_c),
      .sel_o    (sel),
      .stage_o  (stage_idx),
      .term_c_o (term_c)
   );

   // Next state and registered status outputs.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (!hold && term_c) state_d = ST_FIN;
         ST_FIN:  state_d = start ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_FIN);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;

   // Enable and capture strobe are gated by the live hold so a stalled
   // cycle can never capture or clock the MAC units.
   assign sel_last_c = (sel == SEL_W'(SEL_STEPS - 1));
   assign PU_enable  = step_c;
   assign stage_en   = (step_c && sel_last_c) ? (NUM_STAGES'(1) << stage_idx) : '0;
   assign tw_stride  = NUM_STAGES'(tw_stride_f(NUM_STAGES, 32'(stage_idx)));

`ifdef FFT_SEQ_PERF_EN
   logic [15:0] cnt_q, cnt_d;

   // Counts every RUN cycle (held or not), cleared on an accepted start.
   always_comb begin
      cnt_d = cnt_q;
      if (accept_c)
         cnt_d = '0;
      else if (run_c && (cnt_q != 16'hFFFF))
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cycle_count = cnt_q;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
module tb_fft_stage_sequencer;

   logic       clk;
   logic       reset;
   logic       start;
   logic       hold;
   logic [2:0] sel;
   logic       PU_enable;
   logic [2:0] stage_idx;
   logic [4:0] stage_en;
   logic [4:0] tw_stride;
   logic       busy;
   logic       done;
`ifdef FFT_SEQ_PERF_EN
   logic [15:0] cycle_count;
`endif

   fft_stage_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .hold      (hold),
      .sel       (sel),
      .PU_enable (PU_enable),
      .stage_idx (stage_idx),
      .stage_en  (stage_en),
      .tw_stride (tw_stride),
      .busy      (busy),
`ifdef FFT_SEQ_PERF_EN
      .done        (done),
      .cycle_count (cycle_count)
`else
      .done      (done)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   // kind: 0 = busy rise, 1 = stage capture, 2 = done
   typedef struct {
      int       kind;
      int       cyc;
      logic [4:0] se;
      logic [4:0] tw;
      logic [2:0] sel;
      logic [2:0] stg;
   } ev_t;

   ev_t exp_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) tick();
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic ev_t mk(input int kind, input int c, input int s);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.se   = (kind == 1) ? 5'(1 << s) : 5'd0;
      e.tw   = 5'(16 >> s);
      e.sel  = (kind == 1) ? 3'd4 : 3'd0;
      e.stg  = 3'(s);
      return e;
   endfunction

   // Expected events of one run started with base b (cycle n <-> cyc == b+n).
   // Events at or after hold_from slip by hold_len; events at or after stop
   // are not expected (run aborted by reset).
   task automatic push_run(input int b, input int hold_from, input int hold_len, input int stop);
      int c;
      if (1 < stop) exp_q.push_back(mk(0, b + 1, 0));
      for (int s = 0; s < 5; s++) begin
         c = 5 * (s + 1);
         if (c >= hold_from) c += hold_len;
         if (c < stop) exp_q.push_back(mk(1, b + c, s));
      end
      c = 26;
      if (c >= hold_from) c += hold_len;
      if (c < stop) exp_q.push_back(mk(2, b + c, 0));
   endtask

   task automatic do_start(output int b);
      b = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Monitor: pops one expectation per observed DUT event.
   task automatic check_ev(input int kind);
      ev_t e;
      bit  ok;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_event: kind %0d at cyc %0d, none expected", kind, cyc);
         return;
      end
      e  = exp_q.pop_front();
      ok = (e.kind == kind) && (e.cyc == cyc);
      if (kind == 2) ok = ok && (busy == 1'b0);
      else ok = ok && (stage_en == e.se) && (tw_stride == e.tw) &&
                (sel == e.sel) && (stage_idx == e.stg);
      if (!ok) begin
         n_err++;
         $display("FAIL event: got kind %0d cyc %0d se %b tw %0d sel %0d stg %0d busy %0b; expected kind %0d cyc %0d se %b tw %0d sel %0d stg %0d",
                  kind, cyc, stage_en, tw_stride, sel, stage_idx, busy,
                  e.kind, e.cyc, e.se, e.tw, e.sel, e.stg);
      end
   endtask

   logic busy_prev = 1'b0;
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (busy && !busy_prev) check_ev(0);
         if (stage_en != 5'd0)   check_ev(1);
         if (done)               check_ev(2);
      end
      busy_prev = busy;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, b2;
      reset = 1'b0;
      start = 1'b0;
      hold  = 1'b0;

      // Reset and idle outputs.
      repeat (3) tick();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         @(negedge clk);
         chk("idle_outputs", 32'({busy, done, PU_enable, sel, stage_idx, stage_en, tw_stride}),
             32'({1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0, 5'd16}));
      end
      tick();

      // Plain run.
      do_start(b);
      push_run(b, 1000, 0, 1000);
      wait_cyc(b + 26);
`ifdef FFT_SEQ_PERF_EN
      @(negedge clk);
      chk("perf_unstalled", 32'(cycle_count), 32'd25);
`endif
      wait_cyc(b + 30);

      // Start during RUN is ignored.
      do_start(b);
      push_run(b, 1000, 0, 1000);
      wait_cyc(b + 10);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_cyc(b + 32);

      // Three held cycles at stage 2, sel 3.
      do_start(b);
      push_run(b, 14, 3, 1000);
      wait_cyc(b + 14);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("held_freeze", 32'({busy, PU_enable, sel, stage_idx, stage_en}),
             32'({1'b1, 1'b0, 3'd3, 3'd2, 5'd0}));
         tick();
      end
      hold = 1'b0;
      @(negedge clk);
      chk("hold_release", 32'({busy, PU_enable, sel, stage_idx}),
          32'({1'b1, 1'b1, 3'd3, 3'd2}));
      wait_cyc(b + 29);
`ifdef FFT_SEQ_PERF_EN
      @(negedge clk);
      chk("perf_held", 32'(cycle_count), 32'd28);
`endif
      wait_cyc(b + 33);

      // Back-to-back: start in the FIN cycle.
      do_start(b);
      push_run(b, 1000, 0, 1000);
      wait_cyc(b + 26);
      do_start(b2);
      push_run(b2, 1000, 0, 1000);
      wait_cyc(b2 + 30);

      // Reset mid-run at stage 3.
      do_start(b);
      push_run(b, 1000, 0, 17);
      wait_cyc(b + 16);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("abort_outputs", 32'({busy, done, PU_enable, sel, stage_idx, stage_en, tw_stride}),
          32'({1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0, 5'd16}));
      wait_cyc(b + 40);

      // Start accepted in IDLE while hold is high, then a full run.
      hold = 1'b1;
      do_start(b);
      hold = 1'b0;
      push_run(b, 1000, 0, 1000);
      wait_cyc(b + 30);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL missing_events: %0d expected events never seen", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
